mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter in front of a shared 256x8 memory (combinational read,
//   synchronous write). Port 0 is the CPU, port 1 the loader/debug port.
//   Each accepted request occupies two cycles: the grant cycle (ACCESS),
//   then the ack cycle, during which the next request is evaluated again.
//
// Parameters
//   RR_EN            1 = round-robin between ports, 0 = fixed priority (port 0 wins)
// Ports
//   i_clk, i_rstn    clock, asynchronous active-low reset
//   i_reqN/i_weN     request and write qualifier from port N
//   i_addrN/i_wdataN access address and write data from port N
//   o_gntN           one-cycle pulse: request accepted (high during ACCESS)
//   o_ackN           one-cycle pulse: access complete
//   o_rdataN         read data captured at completion, held afterwards
//   o_mem_*          shared memory address / write data / write enable
//   i_mem_data_read  shared memory read data
module mem_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_we0,
    input  logic       i_we1,
    input  logic [7:0] i_addr0,
    input  logic [7:0] i_addr1,
    input  logic [7:0] i_wdata0,
    input  logic [7:0] i_wdata1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_ack0,
    output logic       o_ack1,
    output logic [7:0] o_rdata0,
    output logic [7:0] o_rdata1,
    output logic [7:0] o_mem_addr,
    output logic [7:0] o_mem_data_write,
    output logic       o_mem_write_enable,
    input  logic [7:0] i_mem_data_read
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       any_req;
    logic       win_port;
    logic       last_port;
    logic       cmd_port;
    logic       cmd_we;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;

    // Winner selection; last_port resets to 1 so port 0 wins the first tie.
    always_comb begin
        any_req  = i_req0 | i_req1;
        win_port = i_req1;
        if (i_req0 && i_req1) begin
            win_port = (RR_EN != 0) ? ~last_port : 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (any_req) begin
                state_nxt = ACCESS;
            end
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_port <= 1'b1;
            cmd_port  <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            o_gnt0    <= 1'b0;
            o_gnt1    <= 1'b0;
            o_ack0    <= 1'b0;
            o_ack1    <= 1'b0;
            o_rdata0  <= '0;
            o_rdata1  <= '0;
        end else begin
            o_gnt0 <= 1'b0;
            o_gnt1 <= 1'b0;
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
            if (state == IDLE) begin
                if (any_req) begin
                    last_port <= win_port;
                    cmd_port  <= win_port;
                    cmd_we    <= win_port ? i_we1    : i_we0;
                    cmd_addr  <= win_port ? i_addr1  : i_addr0;
                    cmd_wdata <= win_port ? i_wdata1 : i_wdata0;
                    o_gnt0    <= ~win_port;
                    o_gnt1    <= win_port;
                end
            end else begin
                // Read data is sampled before the write commits at this same
                // edge, so a write returns the old memory contents.
                if (cmd_port) begin
                    o_rdata1 <= i_mem_data_read;
                    o_ack1   <= 1'b1;
                end else begin
                    o_rdata0 <= i_mem_data_read;
                    o_ack0   <= 1'b1;
                end
            end
        end
    end

    assign o_mem_addr         = cmd_addr;
    assign o_mem_data_write   = cmd_wdata;
    assign o_mem_write_enable = (state == ACCESS) && cmd_we;

endmodule
